// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the 7-segment display front-end.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_PC    = 2'd0;
  localparam logic [1:0] SRC_ALU   = 2'd1;
  localparam logic [1:0] SRC_WDATA = 2'd2;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam int          BCD_SHIFTS = 14;
  localparam int unsigned MAX_DISP   = 32'd9999;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and level debouncer; emits a one-clock pulse when
// the accepted level rises.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // Synchronizer, debounce state and rise pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES clocks in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/display_controller.sv
// 7-segment display front-end: source select, change detection and a
// sequential binary-to-BCD conversion feeding four active-low digits.
module display_controller
  import display_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int VAL_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic [VAL_W-1:0] pc_in,
  input  logic [VAL_W-1:0] alu_in,
  input  logic [VAL_W-1:0] wdata_in,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [2:0]       src_led,
  output logic             busy,
  output logic             ovf
);

  logic                  btn_rise_s;
  logic [VAL_W-1:0]      cur_val_s;
  logic [15:0]           bcd_adj_s;

  state_e                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [2:0]            src_led_q, src_led_d;
  logic [VAL_W-1:0]      last_val_q, last_val_d;
  logic [1:0]            last_sel_q, last_sel_d;
  logic                  ovf_pending_q, ovf_pending_d;
  logic [BCD_SHIFTS-1:0] bin_q, bin_d;
  logic [15:0]           bcd_q, bcd_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic [6:0]            hex0_q, hex0_d, hex1_q, hex1_d;
  logic [6:0]            hex2_q, hex2_d, hex3_q, hex3_d;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_next),
    .rise_o(btn_rise_s)
  );

  // Source selection stepping and its one-hot indicator.
  always_comb begin
    sel_d = sel_q;
    if (btn_rise_s) begin
      if (sel_q == SRC_WDATA) begin
        sel_d = SRC_PC;
      end else begin
        sel_d = sel_q + 2'd1;
      end
    end else begin
      sel_d = sel_q;
    end
    case (sel_d)
      SRC_PC:    src_led_d = 3'b001;
      SRC_ALU:   src_led_d = 3'b010;
      SRC_WDATA: src_led_d = 3'b100;
      default:   src_led_d = 3'b001;
    endcase
  end

  // Value mux; PC is shown as an instruction index.
  always_comb begin
    case (sel_q)
      SRC_PC:    cur_val_s = pc_in >> 2;
      SRC_ALU:   cur_val_s = alu_in;
      SRC_WDATA: cur_val_s = wdata_in;
      default:   cur_val_s = '0;
    endcase
  end

  assign bcd_adj_s = bcd_adjust(bcd_q);

  // Conversion sequencer next-state and datapath.
  always_comb begin
    state_d       = state_q;
    last_val_d    = last_val_q;
    last_sel_d    = last_sel_q;
    ovf_pending_d = ovf_pending_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    ovf_d         = ovf_q;
    hex0_d        = hex0_q;
    hex1_d        = hex1_q;
    hex2_d        = hex2_q;
    hex3_d        = hex3_q;
    case (state_q)
      IDLE: begin
        if ((cur_val_s != last_val_q) || (sel_q != last_sel_q)) begin
          last_val_d = cur_val_s;
          last_sel_d = sel_q;
          if (cur_val_s > VAL_W'(MAX_DISP)) begin
            ovf_pending_d = 1'b1;
          end else begin
            ovf_pending_d = 1'b0;
            bin_d         = cur_val_s[BCD_SHIFTS-1:0];
            bcd_d         = 16'd0;
          end
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj_s[14:0], bin_q[BCD_SHIFTS-1]};
        bin_d = {bin_q[BCD_SHIFTS-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BCD_SHIFTS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (ovf_pending_q) begin
          hex0_d = SEG_DASH;
          hex1_d = SEG_DASH;
          hex2_d = SEG_DASH;
          hex3_d = SEG_DASH;
          ovf_d  = 1'b1;
        end else begin
          hex0_d = seg_encode(bcd_q[3:0]);
          hex1_d = seg_encode(bcd_q[7:4]);
          hex2_d = seg_encode(bcd_q[11:8]);
          hex3_d = seg_encode(bcd_q[15:12]);
          ovf_d  = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= SRC_PC;
      src_led_q     <= 3'b001;
      last_val_q    <= '0;
      last_sel_q    <= SRC_PC;
      ovf_pending_q <= 1'b0;
      bin_q         <= '0;
      bcd_q         <= 16'd0;
      cnt_q         <= 4'd0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      hex0_q        <= SEG_DIGIT[0];
      hex1_q        <= SEG_DIGIT[0];
      hex2_q        <= SEG_DIGIT[0];
      hex3_q        <= SEG_DIGIT[0];
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      src_led_q     <= src_led_d;
      last_val_q    <= last_val_d;
      last_sel_q    <= last_sel_d;
      ovf_pending_q <= ovf_pending_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
      hex0_q        <= hex0_d;
      hex1_q        <= hex1_d;
      hex2_q        <= hex2_d;
      hex3_q        <= hex3_d;
    end
  end

  assign hex0    = hex0_q;
  assign hex1    = hex1_q;
  assign hex2    = hex2_q;
  assign hex3    = hex3_q;
  assign src_led = src_led_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule
